// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch control stage of the 3-stage RV32I pipeline.
//               Drives the PC register's next value / load enable, issues
//               instruction-memory requests at the current PC, and captures
//               returned instructions into the IF/ID register. At most one
//               memory request is outstanding. Decode stalls park a returned
//               instruction in a one-entry hold buffer; redirects flush.
//
// Ports       : clk, reset          clock, synchronous active-high reset
//               pc                  current PC from the PC register
//               pc_next, pc_en      next PC value and PC load enable
//               imem_req_valid/_ready, imem_addr   request channel
//               imem_rsp_valid, imem_rsp_data      response channel
//               stall               decode cannot accept IF/ID this cycle
//               redirect_valid/_pc  taken branch/jump pulse and target
//               if_valid, if_pc, if_instr          IF/ID register
//               perf_fetched, perf_bubbles         (FETCH_PERF_CNT_EN only)
//
// Options     : `define FETCH_PERF_CNT_EN adds the two 32-bit counters
//               perf_fetched (instructions written into IF/ID) and
//               perf_bubbles (cycles IF/ID written with if_valid=0).
//
// Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
   parameter int WIDTH       = 32,
   parameter int INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       pc,
   output logic [WIDTH-1:0]       pc_next,
   output logic                   pc_en,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [WIDTH-1:0]       imem_addr,
   input  logic                   imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [WIDTH-1:0]       redirect_pc,
   output logic                   if_valid,
   output logic [WIDTH-1:0]       if_pc,
   output logic [INSTR_WIDTH-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            perf_fetched,
   output logic [31:0]            perf_bubbles
`endif
);

   localparam logic [WIDTH-1:0] c_pc_step = WIDTH'(4);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // free to issue a request at pc
      S_WAIT = 2'd1,   // request outstanding, response wanted
      S_HOLD = 2'd2,   // response parked in hold buffer behind a stall
      S_DROP = 2'd3    // request outstanding, response to be discarded
   } state_t;

   state_t                 r_state;
   logic [WIDTH-1:0]       r_req_pc;
   logic [INSTR_WIDTH-1:0] r_hold_instr;

   logic w_req_valid;
   logic w_accept;
   logic w_deliver;
   logic w_bubble;
   logic w_unused;

   // A redirect suppresses the request in the same cycle so the old-path
   // address never reaches memory.
   assign w_req_valid = !reset && (r_state == S_REQ) && !redirect_valid;
   assign w_accept    = w_req_valid && imem_req_ready;

   // An instruction reaches IF/ID either straight from memory or from the
   // hold buffer; a redirect in the same cycle cancels either source.
   assign w_deliver = !redirect_valid && !stall &&
                      (((r_state == S_WAIT) && imem_rsp_valid) || (r_state == S_HOLD));

   // IF/ID is rewritten with if_valid=0 on a flush, or whenever decode is
   // free and nothing arrives.
   assign w_bubble = redirect_valid || (!stall && !w_deliver);

   assign imem_req_valid = w_req_valid;
   assign imem_addr      = pc;
   assign pc_en          = !reset && (redirect_valid || w_accept);
   assign pc_next        = redirect_valid ? {redirect_pc[WIDTH-1:2], 2'b00}
                                          : pc + c_pc_step;

   // Target offset bits are forced to word alignment and otherwise unused.
   assign w_unused = &{1'b0, redirect_pc[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_REQ;
         r_req_pc     <= '0;
         r_hold_instr <= '0;
         if_valid     <= 1'b0;
         if_pc        <= '0;
         if_instr     <= '0;
      end else begin
         // IF/ID register
         if (w_deliver) begin
            if_valid <= 1'b1;
            if_pc    <= r_req_pc;
            if_instr <= (r_state == S_HOLD) ? r_hold_instr : imem_rsp_data;
         end else if (w_bubble) begin
            if_valid <= 1'b0;
         end

         // Fetch sequencing
         case (r_state)
            S_REQ: begin
               if (w_accept) begin
                  r_req_pc <= pc;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (redirect_valid) begin
                     r_state <= S_REQ;
                  end else if (stall) begin
                     r_hold_instr <= imem_rsp_data;
                     r_state      <= S_HOLD;
                  end else begin
                     r_state <= S_REQ;
                  end
               end else if (redirect_valid) begin
                  r_state <= S_DROP;
               end
            end
            S_HOLD: begin
               if (redirect_valid || !stall) begin
                  r_state <= S_REQ;
               end
            end
            S_DROP: begin
               // A redirect here keeps us in DROP unless the stale response
               // is consumed in this very cycle, which would otherwise leave
               // nothing to wait for.
               if (imem_rsp_valid) begin
                  r_state <= S_REQ;
               end
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_bubbles <= '0;
      end else begin
         if (w_deliver) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (w_bubble) begin
            perf_bubbles <= perf_bubbles + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. The bench owns the PC
//               register and a single-slot instruction memory with settable
//               latency (data = addr ^ 32'hA5A5_0000). A transaction-level
//               model predicts all outputs every cycle; directed scenarios add
//               literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        pc_en;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   always #5 clk = ~clk;

   fetch_ctrl #(.WIDTH(32), .INSTR_WIDTH(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc             (pc),
      .pc_next        (pc_next),
      .pc_en          (pc_en),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   localparam logic [31:0] c_key = 32'hA5A5_0000;

   int n_pass  = 0;
   int n_total = 0;
   int mem_lat = 1;
   bit mon_en  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   // ---------------- environment: PC register + memory ----------------
   bit          s_reset, s_pcen, s_acc, pend;
   logic [31:0] s_pcnext, s_addr, paddr;
   int          cnt;

   initial begin
      pc = 32'd0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; pend = 1'b0; cnt = 0;
      forever begin
         @(negedge clk);
         s_reset  = reset;
         s_pcen   = pc_en;
         s_pcnext = pc_next;
         s_acc    = imem_req_valid && imem_req_ready;
         s_addr   = imem_addr;
         @(posedge clk); #1;
         if (s_reset)     pc = 32'd0;
         else if (s_pcen) pc = s_pcnext;
         imem_rsp_valid = 1'b0;
         if (s_acc) begin pend = 1'b1; cnt = mem_lat; paddr = s_addr; end
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = paddr ^ c_key;
               pend = 1'b0;
            end
         end
      end
   end

   // ---------------- transaction model + per-cycle compare ----------------
   bit          m_out = 0, m_disc = 0, m_buf = 0, m_ifv = 0;
   logic [31:0] m_out_pc = 0, m_buf_instr = 0, m_buf_pc = 0, m_ifpc = 0, m_ifinstr = 0;
   bit          e_req, e_pcen, got;
   logic [31:0] d_pc, d_instr;

   always @(negedge clk) begin
      if (mon_en) begin
         e_req = 1'b0;
         if (reset) begin
            chk("req_valid_in_reset", imem_req_valid, 0);
            chk("pc_en_in_reset", pc_en, 0);
         end else begin
            // Free to request only when nothing is in flight or parked.
            e_req  = !m_out && !m_buf && !redirect_valid;
            e_pcen = redirect_valid || (e_req && imem_req_ready);
            chk("req_valid", imem_req_valid, e_req);
            if (e_req) chk("imem_addr", imem_addr, pc);
            chk("pc_en", pc_en, e_pcen);
            chk("pc_next", pc_next, redirect_valid ? (redirect_pc & ~32'h3) : pc + 32'd4);
         end
         chk("if_valid", if_valid, m_ifv);
         chk("if_pc", if_pc, m_ifpc);
         chk("if_instr", if_instr, m_ifinstr);

         if (reset) begin
            m_out = 0; m_disc = 0; m_buf = 0; m_ifv = 0; m_ifpc = 0; m_ifinstr = 0;
         end else begin
            got = 1'b0;
            if (imem_rsp_valid && m_out) begin
               m_out = 1'b0;
               if (!m_disc && !redirect_valid) begin
                  if (stall) begin
                     m_buf = 1'b1; m_buf_pc = m_out_pc; m_buf_instr = imem_rsp_data;
                  end else begin
                     got = 1'b1; d_pc = m_out_pc; d_instr = imem_rsp_data;
                  end
               end
            end else if (m_buf && !stall && !redirect_valid) begin
               got = 1'b1; d_pc = m_buf_pc; d_instr = m_buf_instr; m_buf = 1'b0;
            end
            if (redirect_valid) begin
               m_buf = 1'b0;
               if (m_out) m_disc = 1'b1;
               m_ifv = 1'b0;
            end else if (!stall) begin
               m_ifv = got;
               if (got) begin m_ifpc = d_pc; m_ifinstr = d_instr; end
            end
            if (e_req && imem_req_ready) begin
               m_out = 1'b1; m_out_pc = pc; m_disc = 1'b0;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic go_to(input logic [31:0] a);
      redirect_valid = 1'b1; redirect_pc = a;
      tick();
      redirect_valid = 1'b0;
   endtask

   // Returns at the negedge of the cycle that issues a request to a.
   task automatic wait_req(input logic [31:0] a, input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_addr == a) ok = 1'b1;
         else tick();
      end
      chk(nm, {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_ifv(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (if_valid) ok = 1'b1;
         else tick();
      end
      chk(nm, {31'd0, ok}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // ---------------- directed scenarios ----------------
   initial begin
      reset = 1'b1; imem_req_ready = 1'b1; stall = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'd0;
      tick();
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_instr", if_instr, 0);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_pc_en", pc_en, 0);
      tick();
      reset = 1'b0;

      // Straight-line fetch, 1-cycle memory
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         wait_ifv("s1_deliver_seen");
         chk("s1_if_pc", if_pc, 32'(k * 4));
         chk("s1_if_instr", if_instr, 32'(k * 4) ^ c_key);
      end

      // Backpressure at pc=0x10
      tick();
      imem_req_ready = 1'b0;
      wait_req(32'h10, "s2_req_seen");
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin tick(); @(negedge clk); end
         chk("s2_req_valid_held", imem_req_valid, 1);
         chk("s2_addr_stable", imem_addr, 32'h10);
         chk("s2_pc_en_low", pc_en, 0);
      end
      tick();
      imem_req_ready = 1'b1;
      @(negedge clk);
      chk("s2_accept_pc_en", pc_en, 1);
      chk("s2_accept_pc_next", pc_next, 32'h14);

      // Stall while the response for 0x20 returns
      tick();
      go_to(32'h20);
      wait_req(32'h20, "s3_req_seen");
      tick();
      stall = 1'b1;
      @(negedge clk);
      tick(); @(negedge clk);
      chk("s3_hold_req_valid", imem_req_valid, 0);
      chk("s3_hold_if_valid", if_valid, 0);
      tick(); @(negedge clk);
      tick();
      stall = 1'b0;
      @(negedge clk);
      tick(); @(negedge clk);
      chk("s3_if_valid", if_valid, 1);
      chk("s3_if_pc", if_pc, 32'h20);
      chk("s3_if_instr", if_instr, 32'h20 ^ c_key);
      chk("s3_next_req", imem_addr, 32'h24);
      chk("s3_next_req_valid", imem_req_valid, 1);

      // Redirect while waiting for 0x40, response 2 cycles later
      tick();
      go_to(32'h40);
      mem_lat = 3;
      wait_req(32'h40, "s4_req_seen");
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      @(negedge clk);
      chk("s4_pc_en", pc_en, 1);
      chk("s4_pc_next", pc_next, 32'h100);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("s4_drop_if_valid", if_valid, 0);
      chk("s4_drop_req_valid", imem_req_valid, 0);
      tick(); @(negedge clk);
      chk("s4_rsp_cycle_req_valid", imem_req_valid, 0);
      tick(); @(negedge clk);
      chk("s4_discarded_if_valid", if_valid, 0);
      chk("s4_new_req_valid", imem_req_valid, 1);
      chk("s4_new_req_addr", imem_addr, 32'h100);

      // Redirect + stall + response in the same cycle
      tick();
      go_to(32'h60);
      mem_lat = 1;
      wait_req(32'h60, "s5_req_seen");
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
      @(negedge clk);
      tick();
      redirect_valid = 1'b0; stall = 1'b0;
      @(negedge clk);
      chk("s5_if_valid", if_valid, 0);
      chk("s5_req_valid", imem_req_valid, 1);
      chk("s5_req_addr", imem_addr, 32'h80);
      tick(); @(negedge clk);
      chk("s5_no_deliver", if_valid, 0);

      // PC wrap, then reset during WAIT with a late response
      tick();
      go_to(32'hFFFF_FFFF);
      mem_lat = 3;
      wait_req(32'hFFFF_FFFC, "s6_req_seen");
      chk("s6_wrap_pc_en", pc_en, 1);
      chk("s6_wrap_pc_next", pc_next, 32'h0);
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("s6_reset_req_valid", imem_req_valid, 0);
      chk("s6_reset_pc_en", pc_en, 0);
      tick();
      reset = 1'b0; imem_req_ready = 1'b0;
      @(negedge clk);
      chk("s6_post_if_valid", if_valid, 0);
      chk("s6_post_if_pc", if_pc, 0);
      tick(); @(negedge clk);
      tick(); @(negedge clk);
      chk("s6_late_if_valid", if_valid, 0);
      chk("s6_late_if_instr", if_instr, 0);
      chk("s6_late_req_addr", imem_addr, 32'h0);
      tick();
      imem_req_ready = 1'b1; mem_lat = 1;
      for (int i = 0; i < 8; i++) tick();
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch control stage of the 3-stage RV32I pipeline.
- Drives the PC register's next-value and enable inputs and issues instruction-memory requests at the current PC.
- Captures returned instructions into the IF/ID pipeline register for decode.
- Handles decode-side stalls and branch/jump redirects, with one outstanding memory request maximum.

Parameters:
- Width, 32, PC/address width in bits.
- InstrWidth, 32, instruction word width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pc  in  Width  current PC from PC register
- pc_next  out  Width  next PC value to PC register
- pc_en  out  1  PC register load enable
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  Width  request address
- imem_rsp_valid  in  1  response valid (one cycle per accepted request, latency ≥1)
- imem_rsp_data  in  InstrWidth  instruction word
- stall  in  1  decode cannot accept IF/ID this cycle
- redirect_valid  in  1  one-cycle branch/jump taken pulse
- redirect_pc  in  Width  redirect target
- if_valid  out  1  IF/ID holds a valid instruction
- if_pc  out  Width  PC of IF/ID instruction
- if_instr  out  InstrWidth  IF/ID instruction

Behaviour:
- Reset state:
  - State REQ; if_valid=0; if_pc=0; if_instr=0; hold buffer empty; req_pc=0.
  - During reset: imem_req_valid=0, pc_en=0.
- FSM states: REQ, WAIT, HOLD, DROP.
- REQ:
  - imem_req_valid = !redirect_valid; imem_addr = pc.
  - On accept (valid & ready): req_pc <= pc; pc_en=1, pc_next = pc+4 (mod 2^Width, wraps); go to WAIT.
- WAIT:
  - On imem_rsp_valid & !stall: if_valid<=1, if_pc<=req_pc, if_instr<=data; go to REQ.
  - On imem_rsp_valid & stall: capture into hold buffer; go to HOLD.
- HOLD: when stall=0, move buffer to IF/ID (if_valid=1); go to REQ.
- IF/ID update rule:
  - When stall=1, IF/ID holds its value.
  - When stall=0 and no instruction is delivered this cycle, if_valid<=0 (bubble); if_pc and if_instr hold.
- Redirect (highest priority, overrides stall):
  - pc_en=1, pc_next={redirect_pc[Width-1:2],2'b00}.
  - Next cycle: if_valid=0.
  - Per-state effect:
    - REQ: no request issued that cycle; stay REQ.
    - WAIT with rsp_valid in the same cycle: response discarded; go to REQ.
    - WAIT without rsp_valid: go to DROP.
    - HOLD: buffer discarded; go to REQ.
    - DROP: stay DROP.
- DROP:
  - No request issued.
  - The next imem_rsp_valid is discarded (IF/ID not written); go to REQ.
- pc_en=0 in every cycle not listed above; pc_next=pc+4 when pc_en=0 (don't-care value, driven deterministically).
- Memory ordering:
  - At most one request outstanding.
  - imem_req_valid never asserted in WAIT/HOLD/DROP.
  - Once asserted in REQ, valid and addr stay stable until accepted unless a redirect arrives.
- Reset mid-operation:
  - Everything returns to reset values next cycle.
  - Any in-flight response is ignored; the memory shares the same reset.
- Throughput: best case one instruction per 2 cycles with 1-cycle memory latency.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32b) and perf_bubbles (32b), both reset to 0.
  - perf_fetched increments on each instruction written into IF/ID.
  - perf_bubbles increments on each cycle IF/ID is written with if_valid=0, including flushes.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then ready=1 and 1-cycle-latency memory returning instr=addr^32'hA5A5_0000 -> requests at 0,4,8; if_pc sequence 0,4,8 with matching if_instr; pc_en pulses once per accept.
- imem_req_ready=0 for 3 cycles with pc=0x10 -> imem_req_valid held high, imem_addr=0x10 stable, pc_en=0 until accept.
- stall=1 while response for pc=0x20 arrives -> state HOLD, IF/ID unchanged; stall drops 2 cycles later -> if_pc=0x20, if_valid=1, then request to 0x24.
- redirect_valid with redirect_pc=0x103 while in WAIT for 0x40, response 2 cycles later -> pc_next=0x100, response for 0x40 discarded, if_valid=0, next request to 0x100.
- redirect in the same cycle as stall=1 and rsp_valid -> if_valid=0 next cycle, no instruction delivered, state REQ.
- pc=0xFFFF_FFFC accepted -> pc_next=0x0000_0000 (wrap); reset asserted during WAIT -> if_valid=0, imem_req_valid=0, late rsp_valid ignored.
